// File: rtl/matrix_ram_arbiter_pkg.sv
// Shared constants and types for the matrix RAM arbiter.
package matrix_ram_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_ROWS       = 8;
    localparam int unsigned DEFAULT_COLS       = 8;

    // Index of one of the two requesters on a port.
    typedef logic req_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; prio names the requester that wins a tie.
module rr_arb2
    import matrix_ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_idx_t prio_q, prio_d;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt[0]) begin
            prio_d = 1'b1;
        end else if (gnt[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/matrix_ram_arbiter.sv
// Arbitrates two writers and two readers onto a single-port-pair matrix RAM
// with one-cycle read latency and same-cycle write-to-read forwarding.
module matrix_ram_arbiter
    import matrix_ram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ROWS       = DEFAULT_ROWS,
    parameter int unsigned COLS       = DEFAULT_COLS,
    localparam int unsigned RW        = $clog2(ROWS),
    localparam int unsigned CW        = $clog2(COLS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              w_valid,
    output logic [1:0]              w_ready,
    input  logic [2*RW-1:0]         w_row,
    input  logic [2*CW-1:0]         w_col,
    input  logic [2*DATA_WIDTH-1:0] w_data,
    input  logic [1:0]              r_valid,
    output logic [1:0]              r_ready,
    input  logic [2*RW-1:0]         r_row,
    input  logic [2*CW-1:0]         r_col,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    ram_we,
    output logic [RW-1:0]           ram_w_row,
    output logic [CW-1:0]           ram_w_col,
    output logic [DATA_WIDTH-1:0]   ram_din,
    output logic [RW-1:0]           ram_r_row,
    output logic [CW-1:0]           ram_r_col,
    input  logic [DATA_WIDTH-1:0]   ram_dout
);

    logic [1:0]            w_gnt, r_gnt;
    req_idx_t              w_sel, r_sel;
    logic                  w_acc, r_acc;
    logic [RW-1:0]         r_row_q;
    logic [CW-1:0]         r_col_q;
    logic [1:0]            rsp_valid_q;
    logic                  fwd_q, fwd_d;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    rr_arb2 u_w_arb (
        .clk (clk),
        .rst (rst),
        .req (w_valid),
        .gnt (w_gnt)
    );

    rr_arb2 u_r_arb (
        .clk (clk),
        .rst (rst),
        .req (r_valid),
        .gnt (r_gnt)
    );

    assign w_ready = w_gnt;
    assign r_ready = r_gnt;
    assign w_sel   = w_gnt[1];
    assign r_sel   = r_gnt[1];
    assign w_acc   = |(w_valid & w_gnt);
    assign r_acc   = |(r_valid & r_gnt);

    always_comb begin
        ram_we    = w_acc;
        ram_w_row = '0;
        ram_w_col = '0;
        ram_din   = '0;
        if (w_acc) begin
            ram_w_row = w_sel ? w_row[2*RW-1:RW] : w_row[RW-1:0];
            ram_w_col = w_sel ? w_col[2*CW-1:CW] : w_col[CW-1:0];
            ram_din   = w_sel ? w_data[2*DATA_WIDTH-1:DATA_WIDTH] : w_data[DATA_WIDTH-1:0];
        end
    end

    // Read address holds its last granted value so the RAM output stays stable.
    always_comb begin
        ram_r_row = r_row_q;
        ram_r_col = r_col_q;
        if (r_acc) begin
            ram_r_row = r_sel ? r_row[2*RW-1:RW] : r_row[RW-1:0];
            ram_r_col = r_sel ? r_col[2*CW-1:CW] : r_col[CW-1:0];
        end
    end

    assign fwd_d = r_acc && w_acc && (ram_w_row == ram_r_row) && (ram_w_col == ram_r_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_q     <= '0;
            r_col_q     <= '0;
            rsp_valid_q <= 2'b00;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            if (r_acc) begin
                r_row_q <= ram_r_row;
                r_col_q <= ram_r_col;
            end
            rsp_valid_q <= r_valid & r_gnt;
            fwd_q       <= fwd_d;
            fwd_data_q  <= ram_din;
        end
    end

    assign rsp_valid = rsp_valid_q;

    always_comb begin
        rsp_data = '0;
        if (|rsp_valid_q) begin
            rsp_data = fwd_q ? fwd_data_q : ram_dout;
        end
    end

endmodule

// File: tb/tb_matrix_ram_arbiter.sv
// Randomised bench for matrix_ram_arbiter against a transaction-level reference model.
module tb_matrix_ram_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned RW = 3;
    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst;
    logic [1:0]    w_valid, w_ready, r_valid, r_ready, rsp_valid;
    logic [5:0]    w_row, w_col, r_row, r_col;
    logic [15:0]   w_data;
    logic [DW-1:0] rsp_data, ram_din, ram_dout;
    logic          ram_we;
    logic [RW-1:0] ram_w_row, ram_r_row;
    logic [CW-1:0] ram_w_col, ram_r_col;

    matrix_ram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_row     (w_row),
        .w_col     (w_col),
        .w_data    (w_data),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_row     (r_row),
        .r_col     (r_col),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ram_we    (ram_we),
        .ram_w_row (ram_w_row),
        .ram_w_col (ram_w_col),
        .ram_din   (ram_din),
        .ram_r_row (ram_r_row),
        .ram_r_col (ram_r_col),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read, returns the pre-write contents on a collision.
    logic [DW-1:0] mem [8][8];
    always @(posedge clk) begin
        if (ram_we) mem[ram_w_row][ram_w_col] <= ram_din;
        ram_dout <= mem[ram_r_row][ram_r_col];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester payloads and reference model state.
    logic [1:0]    wv, rv, last_wg, last_rg;
    logic [2:0]    wr [2], wc [2], rr [2], rc [2];
    logic [7:0]    wd [2];
    logic [7:0]    ref_mem [8][8];
    int            wprio, rprio;
    logic [1:0]    pend_v;
    logic [7:0]    pend_d;
    logic [2:0]    last_rr, last_rc;

    function automatic logic [1:0] arb(input logic [1:0] v, input int p);
        if (v == 2'b11) return (p == 0) ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic model_reset();
        wprio = 0; rprio = 0; pend_v = 2'b00; pend_d = 8'h00;
        last_rr = 3'd0; last_rc = 3'd0;
    endtask

    // Drives one cycle of requests, checks the cycle, then advances the model.
    task automatic step();
        logic [1:0] eg_w, eg_r;
        int wi, ri;
        w_valid = wv; r_valid = rv;
        w_row = {3'd0, wr[1], 3'd0, wr[0]} ;
        w_row = {wr[1], wr[0]}; w_col = {wc[1], wc[0]}; w_data = {wd[1], wd[0]};
        r_row = {rr[1], rr[0]}; r_col = {rc[1], rc[0]};
        eg_w = arb(wv, wprio);
        eg_r = arb(rv, rprio);
        wi = eg_w[1] ? 1 : 0;
        ri = eg_r[1] ? 1 : 0;
        @(negedge clk);
        check("w_ready", w_ready, eg_w);
        check("r_ready", r_ready, eg_r);
        check("ram_we", ram_we, (eg_w != 0));
        check("ram_w_row", ram_w_row, (eg_w != 0) ? wr[wi] : 3'd0);
        check("ram_w_col", ram_w_col, (eg_w != 0) ? wc[wi] : 3'd0);
        check("ram_din", ram_din, (eg_w != 0) ? wd[wi] : 8'd0);
        check("ram_r_row", ram_r_row, (eg_r != 0) ? rr[ri] : last_rr);
        check("ram_r_col", ram_r_col, (eg_r != 0) ? rc[ri] : last_rc);
        check("rsp_valid", rsp_valid, pend_v);
        check("rsp_data", rsp_data, (pend_v != 0) ? pend_d : 8'd0);
        pend_v = eg_r;
        pend_d = 8'd0;
        if (eg_r != 0) begin
            if (eg_w != 0 && wr[wi] == rr[ri] && wc[wi] == rc[ri]) pend_d = wd[wi];
            else pend_d = ref_mem[rr[ri]][rc[ri]];
            rprio = 1 - ri;
            last_rr = rr[ri];
            last_rc = rc[ri];
        end
        if (eg_w != 0) begin
            ref_mem[wr[wi]][wc[wi]] = wd[wi];
            wprio = 1 - wi;
        end
        last_wg = eg_w;
        last_rg = eg_r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_w_ready"}, w_ready, 2'b00);
        check({tag, "_r_ready"}, r_ready, 2'b00);
        check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
        check({tag, "_rsp_data"}, rsp_data, 8'h00);
        check({tag, "_ram_we"}, ram_we, 1'b0);
        check({tag, "_ram_r_row"}, ram_r_row, 3'd0);
        check({tag, "_ram_r_col"}, ram_r_col, 3'd0);
    endtask

    task automatic idle();
        wv = 2'b00; rv = 2'b00;
        for (int i = 0; i < 2; i++) begin
            wr[i] = 3'd0; wc[i] = 3'd0; wd[i] = 8'd0; rr[i] = 3'd0; rc[i] = 3'd0;
        end
    endtask

    function automatic logic [2:0] rand_addr();
        // Half the traffic hits a 2x2 corner so write/read collisions occur often.
        if ($urandom_range(0, 1) == 0) return 3'($urandom_range(0, 1));
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        w_valid = 2'b00; r_valid = 2'b00;
        w_row = '0; w_col = '0; w_data = '0; r_row = '0; r_col = '0;
        model_reset();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) ref_mem[i][j] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Both writers held valid: grants alternate starting with requester 0.
        wv = 2'b11; wr[0] = 3'd7; wc[0] = 3'd7; wd[0] = 8'h11;
        wr[1] = 3'd6; wc[1] = 3'd6; wd[1] = 8'h22;
        repeat (4) step();
        idle();

        // Fill the whole matrix through writer 0.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                wv = 2'b01; wr[0] = 3'(i); wc[0] = 3'(j); wd[0] = 8'(8'h80 + i * 8 + j);
                step();
            end
        end
        idle();

        // Single write then read back through reader 1.
        wv = 2'b01; wr[0] = 3'd2; wc[0] = 3'd3; wd[0] = 8'h5A;
        step();
        idle();
        rv = 2'b10; rr[1] = 3'd2; rc[1] = 3'd3;
        step();
        idle();
        step();

        // Same-cycle write and read of one cell must return the new data.
        wv = 2'b01; wr[0] = 3'd4; wc[0] = 3'd4; wd[0] = 8'h33;
        rv = 2'b01; rr[0] = 3'd4; rc[0] = 3'd4;
        step();
        idle();
        step();

        // Continuous reads from both readers.
        for (int k = 0; k < 6; k++) begin
            rv = 2'b11;
            rr[0] = 3'(k); rc[0] = 3'd1; rr[1] = 3'(k); rc[1] = 3'd5;
            step();
        end
        idle();

        // Randomised traffic; requesters hold payload until accepted.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!wv[i] && $urandom_range(0, 3) != 0) begin
                    wv[i] = 1'b1; wr[i] = rand_addr(); wc[i] = rand_addr();
                    wd[i] = 8'($urandom);
                end
                if (!rv[i] && $urandom_range(0, 3) != 0) begin
                    rv[i] = 1'b1; rr[i] = rand_addr(); rc[i] = rand_addr();
                end
            end
            step();
            wv = wv & ~last_wg;
            rv = rv & ~last_rg;
        end
        idle();

        // Reset lands in a cycle where a read is presented and a response is pending.
        rv = 2'b01; rr[0] = 3'd1; rc[0] = 3'd1;
        step();
        r_valid = 2'b01; w_valid = 2'b00;
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(posedge clk);
        #1 check("midrst_rsp_after_edge", rsp_valid, 2'b00);
        rst = 1'b0;
        #1 check("midrst_rsp_after_release", rsp_valid, 2'b00);
        model_reset();
        rv = 2'b11; rr[0] = 3'd3; rc[0] = 3'd2; rr[1] = 3'd5; rc[1] = 3'd6;
        step();
        idle();
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_ram_arbiter.md
MATRIX_RAM_ARBITER -- requirements
Module: matrix_ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of one matrix element.
REQ-002 Parameter ROWS, default 8, SHALL set the matrix row count; RW = $clog2(ROWS).
REQ-003 Parameter COLS, default 8, SHALL set the matrix column count; CW = $clog2(COLS).
REQ-004 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 w_valid  input  2  SHALL carry the write request, one bit per write requester i.
REQ-007 w_ready  output  2  SHALL be the write grant; the write is accepted when w_valid[i] & w_ready[i].
REQ-008 w_row / w_col / w_data  input  2*RW / 2*CW / 2*DATA_WIDTH  SHALL be the packed row, column and data per requester; slice i is requester i.
REQ-009 r_valid  input  2  SHALL carry the read request per read requester.
REQ-010 r_ready  output  2  SHALL be the read grant.
REQ-011 r_row / r_col  input  2*RW / 2*CW  SHALL be the packed read address per requester.
REQ-012 rsp_valid  output  2  SHALL pulse one cycle when rsp_data belongs to read requester i.
REQ-013 rsp_data  output  DATA_WIDTH  SHALL be the read response data, shared by both requesters.
REQ-014 ram_we, ram_w_row, ram_w_col, ram_din  output  1/RW/CW/DATA_WIDTH  SHALL drive the RAM write port.
REQ-015 ram_r_row, ram_r_col  output  RW/CW  SHALL drive the RAM read port, which has a registered one-cycle read latency.
REQ-016 ram_dout  input  DATA_WIDTH  SHALL be the RAM read data.

Function
REQ-017 Write and read arbitration SHALL be independent; each arbiter grants at most one requester per cycle.
REQ-018 Each arbiter SHALL be two-way round-robin: one request -> grant it; two requests -> grant the requester holding a prio bit; after a grant to i, prio SHALL pass to 1-i.
REQ-019 w_ready/r_ready SHALL be combinational from valid and prio; requesters SHALL NOT make valid depend on ready, and SHALL hold payload stable until accepted.
REQ-020 ram_we SHALL equal |(w_valid & w_ready), with ram_w_row/col/din muxed from the granted slice in the same cycle; ram_w_* SHALL be 0 when no grant is given.
REQ-021 ram_r_row/col SHALL be muxed from the granted read slice in the same cycle, and SHALL hold the last value when no grant is given.
REQ-022 A read accepted at edge t SHALL produce rsp_valid[i]=1 for exactly the cycle following edge t, with rsp_data valid in that cycle (latency 1).
REQ-023 Back-to-back reads SHALL be accepted every cycle, giving a sustained rate of one response per cycle.
REQ-024 Same-cycle read and write to the same (row,col) SHALL return the new write data via a registered forward flag and data; otherwise rsp_data = ram_dout.
REQ-025 rsp_data SHALL be 0 in any cycle where rsp_valid == 0.
REQ-026 Addresses at or above ROWS/COLS (non-power-of-two sizing) SHALL be granted and forwarded unchanged; range checking is the requester's responsibility.

Reset
REQ-027 While rst is high: w_ready=0, r_ready=0, rsp_valid=0, rsp_data=0, ram_we=0, ram_r_row/col=0, both prio bits=0, forward flag=0.
REQ-028 rst asserted mid-operation SHALL drop any pending response; no rsp_valid SHALL be issued for a read accepted in the cycle rst rises.
REQ-029 The first edge after rst deasserts SHALL be able to accept requests.

Structure
REQ-030 A shared package SHALL hold the default DATA_WIDTH/ROWS/COLS constants and the requester-index typedef (1 bit).
REQ-031 One sub-module, rr_arb2 (2-request round-robin arbiter with a prio flop), SHALL be instantiated twice, once for writes and once for reads.

Verification
REQ-032 Only w_valid=01 (row 2, col 3, data 0x5A), then only r_valid=10 at (2,3) -> w_ready=01, ram_we=1; next cycle r_ready=10; one cycle later rsp_valid=10, rsp_data=0x5A.
REQ-033 Both w_valid=11 held for 4 cycles after reset -> grants 01,10,01,10.
REQ-034 Same cycle: write (4,4)=0x33 and read (4,4) from requester 0 -> next cycle rsp_valid=01, rsp_data=0x33, not the old value.
REQ-035 Both read requesters issue continuous reads of distinct cells for 6 cycles -> 6 responses on consecutive cycles, alternating rsp_valid 01/10, with data matching the written values.
REQ-036 Assert rst in the cycle a read is accepted -> rsp_valid stays 0; all outputs are at reset values; after release, r_valid=01 is granted on the first cycle with prio 0.
